sevenseg_capture: RTL and testbench
===================================

# sevenseg_capture

Reads the multiplexed seven-segment display bus (digit-select `an` plus `segment` pattern) produced by the calculator's display path and reconstructs the displayed number. It filters scan-transition ghosting, decodes each digit back to BCD, assembles ones/tens/hundreds into a frame, and outputs the binary value with per-frame valid/error pulses. The block sits on the loopback side of the display bus, for on-board self-check of the displayed result against the LED value.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a digit is accepted; legal range 2–255.
- `TIMEOUT_CYCLES`, default 200000: number of clocks with no accepted digit before `scan_active` drops; legal range 16 to 2^24−1.
- `clk`  in  1  system clock; the display bus is driven from the same clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `an`  in  7  digit select, active-low. `an[0]` = ones, `an[1]` = tens, `an[2]` = hundreds; `an[6:3]` must be high.
- `segment`  in  7  segment pattern, active-low, `segment[0]` = a … `segment[6]` = g.
- `ones`, `tens`, `hundreds`  out  4 each  BCD digits of the last good frame.
- `value`  out  10  binary value of the last good frame, 0–999.
- `frame_valid`  out  1  one-cycle pulse when a good frame completes.
- `frame_err`  out  1  one-cycle pulse when a bad frame completes.
- `changed`  out  1  one-cycle pulse, coincident with `frame_valid`, when the new `value` differs from the previous one.
- `scan_active`  out  1  level; high while digits are being accepted.

## Operation
- **Input sampling:** `an` and `segment` are registered once per clock into `an_q` and `seg_q`.
- **Select classification of `an_q`:**
  - VALID: exactly one of bits [2:0] is low and bits [6:3] are all high.
  - BLANK: all bits high.
  - ILLEGAL: any other pattern.
- **Capture FSM, state SETTLE:**
  - A stability counter counts consecutive cycles in which the pair (`an_q`, `seg_q`) is unchanged. Any change reloads the counter to 1.
  - When the count reaches `STABLE_CYCLES` with a VALID select, the digit is accepted and the FSM moves to HOLD.
  - When the count reaches `STABLE_CYCLES` with an ILLEGAL select, the frame bad flag is set and the FSM moves to HOLD.
  - BLANK is never accepted and does not affect the frame.
- **Capture FSM, state HOLD:** waits for `an_q` to change, then returns to SETTLE. A `seg_q`-only change stays in HOLD, so each select window is accepted at most once.
- **Digit decode (active-low codes):**
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19.
  - 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10.
  - Any other code stores 0 for that digit and sets the frame bad flag.
- **Frame assembly:**
  - Accepted digits are written into staging BCD registers, and a 3-bit captured mask records which digits have arrived.
  - A repeat of an already-captured digit overwrites the staging register (last write wins).
  - When the mask becomes 3'b111, the frame completes. The mask and bad flag are then cleared.
- **Good frame (bad flag clear):**
  - `ones`, `tens` and `hundreds` are updated from staging.
  - `value` = hundreds·100 + tens·10 + ones, computed with shift-add in 10 bits.
  - `frame_valid` pulses; `changed` pulses if the new `value` differs from the previous one.
- **Bad frame:** `frame_err` pulses and all outputs other than the pulse hold their previous values. `frame_valid` and `frame_err` are never high together.
- **Timeout:**
  - An idle counter resets on every accept.
  - When it reaches `TIMEOUT_CYCLES`, `scan_active` goes low and the mask and bad flag are cleared (partial frame discarded).
  - The next accept sets `scan_active` high.

## Timing
- **Reset values:** all outputs 0, FSM in SETTLE, counters 0, mask 0, `an_q`/`seg_q` all-ones. Reset asserted mid-frame discards the partial frame immediately.
- **Accept latency:** a pair driven on the bus at edge n is in `an_q`/`seg_q` after edge n+1. It is accepted at edge n+`STABLE_CYCLES` if held throughout.
- **Frame-output latency:** `frame_valid`/`frame_err` and the updated outputs appear one clock after the completing accept and stay high for exactly one cycle.
- **Minimum rate:** back-to-back frames are supported at one digit every `STABLE_CYCLES`+1 clocks.
- **Simultaneous timeout and accept:** the accept wins; the idle counter clears and the mask is not cleared.

## Test plan
- **Loopback 123:** drive hundreds 0x79, tens 0x24, ones 0x30, each for 10 clocks → `frame_valid` pulses once with `value` = 123, `hundreds`/`tens`/`ones` = 1/2/3, and `changed` = 1. Repeating the same frame → `frame_valid` pulses with `changed` = 0.
- **Ghost rejection:** during a select change, drive a 2-clock glitch of tens select with segment 0x00, then the real ones select with 0x12 (`STABLE_CYCLES` = 4) → the glitch is not accepted and `ones` = 5.
- **Illegal select:** drive `an` = 7'b1111100 stable for 10 clocks, then complete the other digits → `frame_err` pulses, `frame_valid` stays low, and `value` is unchanged.
- **Bad segment pattern:** drive ones with 0x7F (blank) under a VALID select, then complete the frame → `frame_err` pulses. A following good frame for 255 → `value` = 255.
- **Reset and timeout:** assert `rst_n` low after two digits → all outputs read 0 and no frame is reported. Capture two digits, then stall for `TIMEOUT_CYCLES` → `scan_active` drops and the partial frame is discarded; the next full frame is reported correctly.

Source files
------------

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - reconstructs the displayed number from a multiplexed seven-segment bus
module sevenseg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] an,
    input  logic [6:0] segment,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [9:0] value,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       changed,
    output logic       scan_active
);

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    localparam logic [7:0]  STABLE_C   = 8'(STABLE_CYCLES);
    localparam logic [23:0] TIMEOUT_C  = 24'(TIMEOUT_CYCLES);
    localparam logic [23:0] TIMEOUT_M1 = 24'(TIMEOUT_CYCLES - 1);

    // Input sample registers
    logic [6:0] an_q;
    logic [6:0] seg_q;

    // Capture FSM and stability counter
    state_t     state;
    logic [7:0] stab_cnt;
    logic [7:0] stab_next;

    // Frame assembly
    logic [3:0] stage_ones;
    logic [3:0] stage_tens;
    logic [3:0] stage_hundreds;
    logic [2:0] mask;
    logic       bad;
    logic       done_q;
    logic       done_bad_q;

    // Idle supervision
    logic [23:0] idle_cnt;

    // Combinational helpers
    logic       pair_change;
    logic       stab_hit;
    logic       sel_valid;
    logic       sel_blank;
    logic       sel_illegal;
    logic       accept;
    logic       illegal_hit;
    logic       timeout_fire;
    logic [2:0] sel_onehot;
    logic [2:0] mask_next;
    logic       complete;
    logic [3:0] dec_digit;
    logic       dec_bad;
    logic [9:0] new_value;

    // Map an active-low segment pattern back to a BCD digit; unknown codes flag bad
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'h40:   r = {1'b0, 4'd0};
            7'h79:   r = {1'b0, 4'd1};
            7'h24:   r = {1'b0, 4'd2};
            7'h30:   r = {1'b0, 4'd3};
            7'h19:   r = {1'b0, 4'd4};
            7'h12:   r = {1'b0, 4'd5};
            7'h02:   r = {1'b0, 4'd6};
            7'h78:   r = {1'b0, 4'd7};
            7'h00:   r = {1'b0, 4'd8};
            7'h10:   r = {1'b0, 4'd9};
            default: r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    // Classify the select, decode the segments and derive the accept/timeout events
    always_comb begin
        pair_change = (an != an_q) || (segment != seg_q);
        if (pair_change) begin
            stab_next = 8'd1;
        end else if (stab_cnt == 8'hFF) begin
            stab_next = stab_cnt;
        end else begin
            stab_next = stab_cnt + 8'd1;
        end
        stab_hit = (stab_next == STABLE_C);

        sel_blank = (an_q == 7'h7F);
        sel_valid = (an_q[6:3] == 4'hF) &&
                    ((an_q[2:0] == 3'b110) || (an_q[2:0] == 3'b101) || (an_q[2:0] == 3'b011));
        sel_illegal = !sel_valid && !sel_blank;

        accept      = (state == SETTLE) && stab_hit && sel_valid;
        illegal_hit = (state == SETTLE) && stab_hit && sel_illegal;

        // A coincident accept keeps the partial frame alive
        timeout_fire = !accept && (idle_cnt == TIMEOUT_M1);

        sel_onehot = ~an_q[2:0];
        mask_next  = mask | sel_onehot;
        complete   = accept && (mask_next == 3'b111);

        {dec_bad, dec_digit} = seg_decode(seg_q);

        // hundreds*100 + tens*10 + ones as shifts: 100 = 64+32+4, 10 = 8+2
        new_value = {stage_hundreds, 6'b0}
                  + {1'b0, stage_hundreds, 5'b0}
                  + {4'b0, stage_hundreds, 2'b0}
                  + {3'b0, stage_tens, 3'b0}
                  + {5'b0, stage_tens, 1'b0}
                  + {6'b0, stage_ones};
    end

    // Register the display bus once per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 7'h7F;
            seg_q <= 7'h7F;
        end else begin
            an_q  <= an;
            seg_q <= segment;
        end
    end

    // Stability counter and SETTLE/HOLD capture FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= 8'd0;
            state    <= SETTLE;
        end else begin
            stab_cnt <= stab_next;
            case (state)
                SETTLE: begin
                    if (accept || illegal_hit) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // Only a new select re-arms capture; segment-only changes are ignored
                    if (an != an_q) begin
                        state <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

    // Stage accepted digits, track the captured mask and the bad flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_ones     <= 4'd0;
            stage_tens     <= 4'd0;
            stage_hundreds <= 4'd0;
            mask           <= 3'b000;
            bad            <= 1'b0;
            done_q         <= 1'b0;
            done_bad_q     <= 1'b0;
        end else begin
            done_q     <= complete;
            done_bad_q <= complete && (bad || dec_bad);

            if (timeout_fire) begin
                mask <= 3'b000;
                bad  <= 1'b0;
            end

            if (illegal_hit) begin
                bad <= 1'b1;
            end

            if (accept) begin
                case (an_q[2:0])
                    3'b110:  stage_ones     <= dec_digit;
                    3'b101:  stage_tens     <= dec_digit;
                    3'b011:  stage_hundreds <= dec_digit;
                    default: ;
                endcase
                if (complete) begin
                    mask <= 3'b000;
                    bad  <= 1'b0;
                end else begin
                    mask <= mask_next;
                    if (dec_bad) begin
                        bad <= 1'b1;
                    end
                end
            end
        end
    end

    // Idle counter and scan_active level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= 24'd0;
            scan_active <= 1'b0;
        end else if (accept) begin
            idle_cnt    <= 24'd0;
            scan_active <= 1'b1;
        end else if (idle_cnt != TIMEOUT_C) begin
            idle_cnt <= idle_cnt + 24'd1;
            if (timeout_fire) begin
                scan_active <= 1'b0;
            end
        end
    end

    // Publish the completed frame one clock after its final accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones        <= 4'd0;
            tens        <= 4'd0;
            hundreds    <= 4'd0;
            value       <= 10'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            changed     <= 1'b0;
        end else begin
            frame_valid <= done_q && !done_bad_q;
            frame_err   <= done_q && done_bad_q;
            changed     <= done_q && !done_bad_q && (new_value != value);
            if (done_q && !done_bad_q) begin
                ones     <= stage_ones;
                tens     <= stage_tens;
                hundreds <= stage_hundreds;
                value    <= new_value;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - directed table-driven bench for sevenseg_capture
module tb_sevenseg_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;

    localparam logic [6:0] A_O   = 7'b1111110;
    localparam logic [6:0] A_T   = 7'b1111101;
    localparam logic [6:0] A_H   = 7'b1111011;
    localparam logic [6:0] A_B   = 7'b1111111;
    localparam logic [6:0] A_ILL = 7'b1111100;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] an;
    logic [6:0] segment;
    logic [3:0] ones, tens, hundreds;
    logic [9:0] value;
    logic       frame_valid, frame_err, changed, scan_active;

    sevenseg_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an),
        .segment    (segment),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .value      (value),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .changed    (changed),
        .scan_active(scan_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] an_s;
        logic [27:0] seg_s;
        int          dur;
        int          exp_valid;
        int          exp_err;
        int          exp_changed;
        int          exp_value;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    int n_valid = 0;
    int n_err = 0;
    int n_chg = 0;
    int n_both = 0;
    int n_orphan = 0;

    // Cumulative pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (changed) n_chg++;
        if (frame_valid && frame_err) n_both++;
        if (changed && !frame_valid) n_orphan++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] a, input logic [6:0] s, input int n);
        an      = a;
        segment = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input int exp_value);
        check({tag, " value"}, int'(value), exp_value);
        check({tag, " hundreds"}, int'(hundreds), exp_value / 100);
        check({tag, " tens"}, int'(tens), (exp_value / 10) % 10);
        check({tag, " ones"}, int'(ones), exp_value % 10);
    endtask

    function automatic vec_t mkv(input logic [6:0] a0, input logic [6:0] s0,
                                 input logic [6:0] a1, input logic [6:0] s1,
                                 input logic [6:0] a2, input logic [6:0] s2,
                                 input logic [6:0] a3, input logic [6:0] s3,
                                 input int dur, input int ev, input int ee,
                                 input int ech, input int eval);
        vec_t v;
        v.an_s        = {a3, a2, a1, a0};
        v.seg_s       = {s3, s2, s1, s0};
        v.dur         = dur;
        v.exp_valid   = ev;
        v.exp_err     = ee;
        v.exp_changed = ech;
        v.exp_value   = eval;
        return v;
    endfunction

    vec_t vecs[11];
    int   v0, e0, c0;
    int   fv[7];

    initial begin
        vecs[0]  = mkv(A_H, S1, A_T, S2, A_O, S3, A_B, SB, 10, 1, 0, 1, 123);
        vecs[1]  = mkv(A_H, S1, A_T, S2, A_O, S3, A_B, SB, 10, 1, 0, 0, 123);
        vecs[2]  = mkv(A_ILL, S3, A_H, S9, A_T, S8, A_O, S7, 10, 0, 1, 0, 123);
        vecs[3]  = mkv(A_H, S2, A_T, S4, A_O, SB, A_B, SB, 10, 0, 1, 0, 123);
        vecs[4]  = mkv(A_H, S2, A_T, S5, A_O, S5, A_B, SB, 10, 1, 0, 1, 255);
        vecs[5]  = mkv(A_H, S9, A_T, S9, A_O, S9, A_B, SB, 10, 1, 0, 1, 999);
        vecs[6]  = mkv(A_H, S0, A_T, S0, A_O, S0, A_B, SB, 10, 1, 0, 1, 0);
        vecs[7]  = mkv(A_O, S6, A_T, S0, A_H, S8, A_B, SB, 10, 1, 0, 1, 806);
        vecs[8]  = mkv(A_O, S1, A_T, S4, A_O, S2, A_H, S0, 10, 1, 0, 1, 42);
        vecs[9]  = mkv(A_H, S4, A_T, S5, A_O, S6, A_B, SB, 5, 1, 0, 1, 456);
        vecs[10] = mkv(A_H, S4, A_T, S5, A_O, S6, A_B, SB, 5, 1, 0, 0, 456);

        an      = A_B;
        segment = SB;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);

        check_outputs("reset", 0);
        check("reset frame_valid", int'(frame_valid), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset changed", int'(changed), 0);
        check("reset scan_active", int'(scan_active), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of whole frames
        for (int i = 0; i < 11; i++) begin
            v0 = n_valid;
            e0 = n_err;
            c0 = n_chg;
            for (int k = 0; k < 4; k++) begin
                drive(vecs[i].an_s[k*7 +: 7], vecs[i].seg_s[k*7 +: 7], vecs[i].dur);
            end
            drive(A_B, SB, 4);
            check($sformatf("vec%0d valid pulses", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d err pulses", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d changed pulses", i), n_chg - c0, vecs[i].exp_changed);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_value);
            if (i == 0) check("scan_active after frame", int'(scan_active), 1);
        end

        // Ghost rejection: short tens glitch between hundreds and ones
        v0 = n_valid;
        drive(A_T, S2, 10);
        drive(A_H, S1, 10);
        drive(A_T, S8, 2);
        drive(A_O, S5, 10);
        drive(A_B, SB, 4);
        check("ghost valid pulses", n_valid - v0, 1);
        check_outputs("ghost", 125);

        // Exact output latency of the completing digit
        drive(A_H, S3, 10);
        drive(A_T, S3, 10);
        an      = A_O;
        segment = S3;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            fv[k] = int'(frame_valid);
        end
        check("latency pulse at 4", fv[4], 0);
        check("latency pulse at 5", fv[5], 1);
        check("latency pulse at 6", fv[6], 0);
        drive(A_O, S3, 4);
        drive(A_B, SB, 4);
        check_outputs("latency", 333);

        // Reset in the middle of a frame
        drive(A_H, S1, 10);
        drive(A_T, S1, 10);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs("midreset", 0);
        check("midreset scan_active", int'(scan_active), 0);
        check("midreset frame_valid", int'(frame_valid), 0);
        rst_n = 1'b1;
        v0 = n_valid;
        e0 = n_err;
        drive(A_O, S1, 10);
        drive(A_T, S4, 10);
        check("post-reset no frame", n_valid - v0, 0);
        check("post-reset no err", n_err - e0, 0);
        check("scan_active before stall", int'(scan_active), 1);

        // Stall past the timeout, partial frame must be discarded
        drive(A_B, SB, TIMEOUT + 16);
        check("scan_active after timeout", int'(scan_active), 0);
        drive(A_H, S7, 10);
        check("timeout partial discarded", n_valid - v0, 0);
        check("scan_active after accept", int'(scan_active), 1);
        c0 = n_chg;
        drive(A_T, S2, 10);
        drive(A_O, S8, 10);
        drive(A_B, SB, 4);
        check("timeout frame valid", n_valid - v0, 1);
        check("timeout frame changed", n_chg - c0, 1);
        check_outputs("timeout", 728);

        check("valid and err together", n_both, 0);
        check("changed without valid", n_orphan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
